// File: rtl/mspe_pkg.sv
// Shared types and default widths for the MSPE source arbiter.
package mspe_pkg;

  localparam int unsigned DefaultDataW = 512;
  localparam int unsigned DefaultCntW  = 32;
  localparam int unsigned DefaultLenW  = 16;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHdr  = 2'd1,
    StData = 2'd2
  } state_e;

endpackage

// File: rtl/mspe_rr_arb.sv
// Request arbiter: round-robin from last+1 with wrap, or fixed lowest-index priority.
module mspe_rr_arb #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned IDX_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic [CHANNELS-1:0] request,
  input  logic                mode,
  input  logic [IDX_W-1:0]    last,
  output logic [CHANNELS-1:0] grant,
  output logic                grant_valid
);

  int unsigned      k;
  logic [IDX_W-1:0] idx;

  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    k           = 0;
    idx         = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      k   = mode ? i : (32'(last) + 32'd1 + i) % CHANNELS;
      idx = IDX_W'(k);
      if (!grant_valid && request[idx]) begin
        grant_valid = 1'b1;
        grant[idx]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mspe_src_arbiter.sv
// Pulls length-prefixed packets from per-core show-ahead FIFOs and streams the
// payload onto a single registered valid/ready source, one packet at a time.
module mspe_src_arbiter
  import mspe_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned DATA_W   = DefaultDataW,
  parameter int unsigned CNT_W    = DefaultCntW,
  parameter int unsigned LEN_W    = DefaultLenW,
  localparam int unsigned CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [CHANNELS*DATA_W-1:0] ch_q,
  input  logic [CHANNELS*CNT_W-1:0]  ch_count,
  output logic [CHANNELS-1:0]        ch_re,
  input  logic [CHANNELS-1:0]        ch_enable,
  input  logic                       prio_mode,
  output logic [DATA_W-1:0]          src_data,
  output logic                       src_valid,
  output logic                       src_sop,
  output logic                       src_eop,
  input  logic                       src_ready,
  output logic                       busy,
  output logic [CH_W-1:0]            cur_ch,
  output logic                       pkt_done
);

  state_e            state_q, state_d;
  logic [CH_W-1:0]   cur_ch_q, cur_ch_d;
  logic [CH_W-1:0]   last_q, last_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              first_q, first_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              sop_q, sop_d;
  logic              eop_q, eop_d;

  logic [DATA_W-1:0]   heads [CHANNELS];
  logic [DATA_W-1:0]   cur_head;
  logic [CHANNELS-1:0] eligible;
  logic [CHANNELS-1:0] grant;
  logic                grant_valid;
  logic [CH_W-1:0]     grant_idx;

  // A channel only qualifies once the whole packet (header + L beats) is buffered.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [LEN_W:0] need;
    assign heads[c]    = ch_q[c*DATA_W +: DATA_W];
    assign need        = {1'b0, heads[c][LEN_W-1:0]} + (LEN_W+1)'(1);
    assign eligible[c] = ch_enable[c] && (ch_count[c*CNT_W +: CNT_W] >= CNT_W'(need));
  end

  assign cur_head = heads[cur_ch_q];

  mspe_rr_arb #(
    .CHANNELS (CHANNELS),
    .IDX_W    (CH_W)
  ) u_arb (
    .request     (eligible),
    .mode        (prio_mode),
    .last        (last_q),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  always_comb begin
    grant_idx = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (grant[c]) grant_idx = CH_W'(c);
    end
  end

  always_comb begin
    state_d  = state_q;
    cur_ch_d = cur_ch_q;
    last_d   = last_q;
    rem_d    = rem_q;
    first_d  = first_q;
    data_d   = data_q;
    valid_d  = valid_q && !src_ready;
    sop_d    = sop_q;
    eop_d    = eop_q;
    ch_re    = '0;
    pkt_done = 1'b0;
    case (state_q)
      StIdle: begin
        if (grant_valid) begin
          cur_ch_d = grant_idx;
          last_d   = grant_idx;
          state_d  = StHdr;
        end
      end
      StHdr: begin
        ch_re[cur_ch_q] = 1'b1;
        rem_d           = cur_head[LEN_W-1:0];
        first_d         = 1'b1;
        if (cur_head[LEN_W-1:0] == '0) begin
          pkt_done = 1'b1;
          state_d  = StIdle;
        end else begin
          state_d = StData;
        end
      end
      StData: begin
        // Output slot is free or being drained this cycle.
        if (!valid_q || src_ready) begin
          ch_re[cur_ch_q] = 1'b1;
          data_d          = cur_head;
          valid_d         = 1'b1;
          sop_d           = first_q;
          eop_d           = (rem_q == LEN_W'(1));
          rem_d           = rem_q - LEN_W'(1);
          first_d         = 1'b0;
          if (rem_q == LEN_W'(1)) begin
            pkt_done = 1'b1;
            state_d  = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      cur_ch_q <= '0;
      last_q   <= CH_W'(CHANNELS - 1);
      rem_q    <= '0;
      first_q  <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      sop_q    <= 1'b0;
      eop_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_ch_q <= cur_ch_d;
      last_q   <= last_d;
      rem_q    <= rem_d;
      first_q  <= first_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      sop_q    <= sop_d;
      eop_q    <= eop_d;
    end
  end

  assign src_data  = data_q;
  assign src_valid = valid_q;
  assign src_sop   = sop_q;
  assign src_eop   = eop_q;
  assign cur_ch    = cur_ch_q;
  assign busy      = (state_q != StIdle) || valid_q;

endmodule

// File: tb/tb_mspe_src_arbiter.sv
// Scoreboard bench for mspe_src_arbiter: FIFO models feed packets, a monitor
// checks every accepted beat against per-channel expected queues.
module tb_mspe_src_arbiter;

  localparam int unsigned CH = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 8;
  localparam int unsigned LW = 4;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          sop;
    logic          eop;
  } beat_t;

  logic             clk;
  logic             reset_n;
  logic [CH*DW-1:0] ch_q;
  logic [CH*CW-1:0] ch_count;
  logic [CH-1:0]    ch_re;
  logic [CH-1:0]    ch_enable;
  logic             prio_mode;
  logic [DW-1:0]    src_data;
  logic             src_valid, src_sop, src_eop, src_ready;
  logic             busy;
  logic [1:0]       cur_ch;
  logic             pkt_done;

  int total = 0;
  int bad = 0;
  logic [DW-1:0] fifo [CH][$];
  beat_t         exp_q [CH][$];
  int            order_q [$];
  int            cnt_limit [CH];
  int            pops [CH];
  int            n_acc = 0;
  int            n_valid = 0;
  int            n_done = 0;
  int            ready_mode = 0;
  int            pat = 0;
  logic [CH-1:0] re_s;

  mspe_src_arbiter #(
    .CHANNELS (CH),
    .DATA_W   (DW),
    .CNT_W    (CW),
    .LEN_W    (LW)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ch_q      (ch_q),
    .ch_count  (ch_count),
    .ch_re     (ch_re),
    .ch_enable (ch_enable),
    .prio_mode (prio_mode),
    .src_data  (src_data),
    .src_valid (src_valid),
    .src_sop   (src_sop),
    .src_eop   (src_eop),
    .src_ready (src_ready),
    .busy      (busy),
    .cur_ch    (cur_ch),
    .pkt_done  (pkt_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Packet: header word with length in low bits, then L tagged payload words.
  task automatic push_pkt(input int c, input int l);
    logic [DW-1:0] w;
    w = $urandom;
    w[LW-1:0] = LW'(l);
    fifo[c].push_back(w);
    for (int i = 0; i < l; i++) begin
      w = {4'(c), 28'($urandom)};
      fifo[c].push_back(w);
      exp_q[c].push_back({w, (i == 0), (i == l - 1)});
    end
  endtask

  function automatic bit all_empty();
    for (int c = 0; c < CH; c++) begin
      if (fifo[c].size() != 0 || exp_q[c].size() != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic refresh();
    for (int c = 0; c < CH; c++) begin
      int sz = fifo[c].size();
      ch_q[c*DW +: DW]     = (sz > 0) ? fifo[c][0] : '0;
      ch_count[c*CW +: CW] = CW'((sz > cnt_limit[c]) ? cnt_limit[c] : sz);
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (n < 5000 && !(all_empty() && !busy && !src_valid)) begin
      @(negedge clk);
      n++;
    end
    chk(name, (n < 5000), 1);
    repeat (2) @(negedge clk);
  endtask

  // FIFO model: pops follow ch_re as seen mid-cycle, applied just after the edge.
  initial begin
    for (int c = 0; c < CH; c++) begin
      cnt_limit[c] = 255;
      pops[c]      = 0;
    end
    ch_q = '0;
    ch_count = '0;
    refresh();
    forever begin
      @(negedge clk);
      re_s = reset_n ? ch_re : '0;
      if (re_s != '0) begin
        chk("re_onehot", $countones(re_s), 1);
        for (int c = 0; c < CH; c++) begin
          if (re_s[c]) chk("re_nonempty", (ch_count[c*CW +: CW] != 0), 1);
        end
      end
      @(posedge clk);
      #1;
      for (int c = 0; c < CH; c++) begin
        if (re_s[c] && fifo[c].size() > 0) begin
          void'(fifo[c].pop_front());
          pops[c]++;
        end
      end
      refresh();
    end
  end

  initial begin
    src_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1: begin
          src_ready = (pat % 3 != 1) && (pat % 3 != 2);
          pat++;
        end
        2: src_ready = 1'($urandom_range(0, 1));
        default: src_ready = 1'b1;
      endcase
    end
  end

  // Monitor: consumes accepted beats and checks hold-while-stalled.
  initial begin
    logic  stall;
    beat_t prev;
    beat_t got;
    int    c;
    stall = 1'b0;
    prev  = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        stall = 1'b0;
      end else begin
        if (stall) chk("hold", {src_valid, src_data, src_sop, src_eop}, {1'b1, prev});
        if (pkt_done) n_done++;
        if (src_valid) begin
          n_valid++;
          if (src_ready) begin
            got = {src_data, src_sop, src_eop};
            c   = int'(src_data[DW-1:DW-4]);
            n_acc++;
            if (src_sop) order_q.push_back(c);
            if (c >= CH || exp_q[c].size() == 0) begin
              total++;
              bad++;
              $display("FAIL unexpected_beat actual=%0h required=none", got);
            end else begin
              chk("beat", got, exp_q[c].pop_front());
            end
          end
        end
        stall = src_valid && !src_ready;
        prev  = {src_data, src_sop, src_eop};
      end
    end
  end

  initial begin
    int a0, d0, v0, p0;
    int npk;
    bit found;
    reset_n   = 1'b0;
    ch_enable = '1;
    prio_mode = 1'b0;
    #3;
    chk("rst_valid", src_valid, 0);
    chk("rst_sop", src_sop, 0);
    chk("rst_eop", src_eop, 0);
    chk("rst_data", src_data, 0);
    chk("rst_re", ch_re, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", pkt_done, 0);
    chk("rst_cur", cur_ch, 0);
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;

    // Basic 3-beat packet on ch0
    a0 = n_acc; d0 = n_done;
    push_pkt(0, 3);
    wait_idle("t1_drain");
    chk("t1_beats", n_acc - a0, 3);
    chk("t1_done", n_done - d0, 1);

    // Round-robin vs fixed priority with last grant = 1
    push_pkt(1, 1);
    wait_idle("t2_prep");
    order_q.delete();
    push_pkt(1, 2);
    push_pkt(2, 2);
    wait_idle("t2_rr_drain");
    chk("t2_rr_n", order_q.size(), 2);
    chk("t2_rr_first", order_q[0], 2);
    chk("t2_rr_second", order_q[1], 1);
    prio_mode = 1'b1;
    order_q.delete();
    push_pkt(1, 2);
    push_pkt(2, 2);
    wait_idle("t2_fp_drain");
    chk("t2_fp_first", order_q[0], 1);
    chk("t2_fp_second", order_q[1], 2);
    prio_mode = 1'b0;

    // Incomplete packet must not start
    cnt_limit[0] = 3;
    a0 = n_acc; v0 = n_valid; p0 = pops[0];
    push_pkt(0, 4);
    repeat (10) @(negedge clk);
    chk("t3_no_pop", pops[0] - p0, 0);
    chk("t3_no_valid", n_valid - v0, 0);
    chk("t3_idle", busy, 0);
    cnt_limit[0] = 5;
    wait_idle("t3_drain");
    chk("t3_beats", n_acc - a0, 4);
    cnt_limit[0] = 255;

    // Zero-length packet on ch3
    d0 = n_done; v0 = n_valid; p0 = pops[3];
    push_pkt(3, 0);
    wait_idle("t5_drain");
    chk("t5_pops", pops[3] - p0, 1);
    chk("t5_done", n_done - d0, 1);
    chk("t5_no_valid", n_valid - v0, 0);

    // Backpressure pattern
    pat = 0;
    ready_mode = 1;
    a0 = n_acc;
    push_pkt(1, 4);
    wait_idle("t4_drain");
    chk("t4_beats", n_acc - a0, 4);
    ready_mode = 0;

    // Reset in the middle of a packet
    push_pkt(0, 5);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (src_valid && !src_sop) found = 1'b1;
    end
    chk("t6_beat2_seen", found, 1);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_valid", src_valid, 0);
    chk("t6_re", ch_re, 0);
    chk("t6_busy", busy, 0);
    chk("t6_cur", cur_ch, 0);
    for (int c = 0; c < CH; c++) begin
      fifo[c].delete();
      exp_q[c].delete();
    end
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    chk("t6_post_busy", busy, 0);
    chk("t6_post_re", ch_re, 0);
    chk("t6_post_valid", src_valid, 0);

    // Random traffic, enables and priority mode
    ready_mode = 2;
    d0 = n_done;
    npk = 0;
    for (int it = 0; it < 80; it++) begin
      if ($urandom_range(0, 2) != 0) begin
        push_pkt(int'($urandom_range(0, CH - 1)), int'($urandom_range(0, 6)));
        npk++;
      end
      if ($urandom_range(0, 4) == 0) ch_enable = CH'($urandom);
      if ($urandom_range(0, 5) == 0) prio_mode = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 5)) @(negedge clk);
    end
    ch_enable = '1;
    wait_idle("rand_drain");
    chk("rand_pkts", n_done - d0, npk);
    for (int c = 0; c < CH; c++) chk("rand_leftover", exp_q[c].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mspe_src_arbiter.md
MSPE_SRC_ARBITER -- requirements
Module: mspe_src_arbiter

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, number of per-core source FIFOs (1..32).
REQ-002 SHALL have parameter DATA_W, default 512, stream beat width.
REQ-003 SHALL have parameter CNT_W, default 32, FIFO read-count width.
REQ-004 SHALL have parameter LEN_W, default 16, header length-field width (LEN_W < CNT_W).
REQ-005 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port ch_q  input  CHANNELS*DATA_W  show-ahead FIFO heads; channel c at [c*DATA_W +: DATA_W].
REQ-008 SHALL have port ch_count  input  CHANNELS*CNT_W  FIFO occupancy in beats per channel.
REQ-009 SHALL have port ch_re  output  CHANNELS  one-hot pop strobe per channel.
REQ-010 SHALL have port ch_enable  input  CHANNELS  eligibility mask (core_run style).
REQ-011 SHALL have port prio_mode  input  1  0 = round-robin, 1 = fixed priority (lowest index wins).
REQ-012 SHALL have ports src_data DATA_W, src_valid, src_sop, src_eop outputs and src_ready input  streaming source.
REQ-013 SHALL have ports busy  output  1, cur_ch  output  $clog2(CHANNELS) (min 1), pkt_done  output  1 (one-cycle pulse).

Function
REQ-014 Packet format in each FIFO SHALL be one header beat (length L = bits [LEN_W-1:0] beats) followed by L payload beats; header SHALL NOT be emitted.
REQ-015 Channel c SHALL be eligible when ch_enable[c]=1 and ch_count[c] >= L+1, L+1 computed at LEN_W+1 bits, compared zero-extended to CNT_W; ch_count=0 never eligible.
REQ-016 FSM SHALL have states IDLE, HDR, DATA.
REQ-017 IDLE: if any channel eligible, grant per prio_mode, latch cur_ch, go HDR; else stay.
REQ-018 Round-robin SHALL search from last granted+1 upward with wrap CHANNELS-1 -> 0; last-granted pointer resets to CHANNELS-1 (channel 0 searched first).
REQ-019 HDR: ch_re[cur_ch]=1 for exactly one cycle, remaining <= L; L=0 -> pulse pkt_done, go IDLE; else go DATA.
REQ-020 DATA: when (!src_valid || src_ready), pop cur_ch, load src_data <= head, src_valid <= 1, src_sop <= first beat, src_eop <= (remaining==1), decrement remaining.
REQ-021 On pop of last beat SHALL pulse pkt_done and go IDLE; next arbitration may overlap the pending last beat.
REQ-022 Output register SHALL hold src_data/sop/eop/valid stable while src_valid=1 and src_ready=0.
REQ-023 src_valid SHALL drop the cycle after acceptance when no new beat is loaded.
REQ-024 Throughput SHALL be one beat/cycle with src_ready held high; header costs one bubble cycle per packet.
REQ-025 ch_re SHALL never pop more than one channel per cycle, never pop a channel with ch_count=0.
REQ-026 ch_enable deassert mid-packet SHALL NOT abort the packet; it affects arbitration only.
REQ-027 prio_mode SHALL be sampled only in IDLE.
REQ-028 busy SHALL be 1 in HDR/DATA or while src_valid=1.

Reset
REQ-029 While reset_n=0: state IDLE, ch_re=0, src_valid=0, src_sop=0, src_eop=0, src_data=0, pkt_done=0, cur_ch=0, busy=0, remaining=0.
REQ-030 Reset assertion mid-packet SHALL abandon the packet immediately; FIFO contents are the owner's responsibility.

Structure
REQ-031 Package mspe_pkg SHALL hold the FSM state enum and default DATA_W/CNT_W/LEN_W constants.
REQ-032 Grant logic SHALL be sub-module mspe_rr_arb (request, mode, last pointer -> one-hot grant, valid).

Verification
REQ-033 ch0 header L=3 + 3 beats, src_ready=1 -> 3 beats on src, sop on beat1, eop on beat3, pkt_done once.
REQ-034 ch1 and ch2 each hold L=2 packets, prio_mode=0, last grant=1 -> ch2 served before ch1; with prio_mode=1 -> ch1 first.
REQ-035 ch0 count=3 with header L=4 -> no pop, src_valid stays 0; count raised to 5 -> packet emitted.
REQ-036 L=4 packet, src_ready toggles 1,0,0,1,... -> data held stable while stalled, exactly 4 beats accepted, no loss/duplication.
REQ-037 header L=0 on ch3 -> single ch_re pulse, pkt_done pulse, no src_valid.
REQ-038 reset_n low during beat 2 of L=5 -> src_valid=0, ch_re=0 same cycle; after release FSM in IDLE.
